expansion_input_filter: RTL and testbench



---
 rtl/expansion_pkg.sv | 20 ++
 rtl/expansion_debounce_bit.sv | 66 ++++++
 rtl/expansion_input_filter.sv | 72 +++++++
 tb/tb_expansion_input_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/expansion_pkg.sv
// Shared constants and elaboration helpers for the expansion input filter.
// Covers the debounce counter width, DEBOUNCE range handling and tick counter sizing.
package expansion_pkg;

    localparam int CNT_W = 4;

    function automatic bit debounce_ok(input int d);
        return (d >= 1) && (d <= 15);
    endfunction

    // Out-of-range DEBOUNCE degrades to single-sample acceptance.
    function automatic logic [CNT_W-1:0] debounce_limit(input int d);
        return debounce_ok(d) ? CNT_W'(d - 1) : '0;
    endfunction

    function automatic int tick_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/expansion_debounce_bit.sv
// One expansion input: consecutive-sample debounce counter, filtered level,
// and sticky rise/fall event flags with write-1-to-clear.
module expansion_debounce_bit
    import expansion_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sample,
    input  logic flag_clear,
    output logic filtered,
    output logic rise_flag,
    output logic fall_flag,
    output logic update
);

    localparam logic [CNT_W-1:0] LIMIT = debounce_limit(DEBOUNCE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        accept = 1'b0;
        if (tick) begin
            if (sample == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == LIMIT) begin
                filt_d = sample;
                cnt_d  = '0;
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A new event outranks a clear strobe in the same cycle.
        rise_d = (rise_q & ~flag_clear) | (accept & sample);
        fall_d = (fall_q & ~flag_clear) | (accept & ~sample);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filtered  = filt_q;
    assign rise_flag = rise_q;
    assign fall_flag = fall_q;
    assign update    = accept;

endmodule

// File: rtl/expansion_input_filter.sv
// Debounce and edge-capture stage for the shift-register I/O expander inputs.
// Holds the sample tick divider, input inversion, change pulse and irq register.
module expansion_input_filter
    import expansion_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               SAMPLE_DIV = 1000,
    parameter int               DEBOUNCE   = 4,
    parameter logic [WIDTH-1:0] INVERT     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_filtered,
    output logic [WIDTH-1:0] rise_flags,
    output logic [WIDTH-1:0] fall_flags,
    input  logic [WIDTH-1:0] flag_clear,
    output logic             changed,
    output logic             irq
);

    localparam int            TW     = tick_w(SAMPLE_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(SAMPLE_DIV - 1);

    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tick;
    logic             changed_q, changed_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] update;

    assign sample = data_in ^ INVERT;
    assign tick   = (tcnt_q == '0);

    always_comb begin
        tcnt_d    = tick ? RELOAD : tcnt_q - TW'(1);
        changed_d = |update;
        irq_d     = |(rise_flags | fall_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q    <= RELOAD;
            changed_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            changed_q <= changed_d;
            irq_q     <= irq_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        expansion_debounce_bit #(
            .DEBOUNCE(DEBOUNCE)
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .sample    (sample[i]),
            .flag_clear(flag_clear[i]),
            .filtered  (data_filtered[i]),
            .rise_flag (rise_flags[i]),
            .fall_flag (fall_flags[i]),
            .update    (update[i])
        );
    end

    assign changed = changed_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_expansion_input_filter.sv
// Directed bench for expansion_input_filter: cycle model plus literal checks.
// Instance a uses no inversion, instance b inverts bit 7.
module tb_expansion_input_filter;

    localparam int         W     = 8;
    localparam int         DIV   = 4;
    localparam int         DB    = 3;
    localparam logic [7:0] INV_B = 8'h80;

    typedef struct packed {
        logic [W-1:0]      filt;
        logic [W-1:0]      rise;
        logic [W-1:0]      fall;
        logic              chg;
        logic              irq;
        logic [W-1:0][7:0] run;
    } mdl_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_a = '0, clr_a = '0, din_b = '0, clr_b = '0;
    logic [7:0] filt_a, rise_a, fall_a, filt_b, rise_b, fall_b;
    logic       chg_a, irq_a, chg_b, irq_b;
    int         n_checks = 0;
    int         n_fail   = 0;
    mdl_t       ma, mb;
    int         m_cyc = 0;

    always #5 clk = ~clk;

    expansion_input_filter #(
        .WIDTH(W), .SAMPLE_DIV(DIV), .DEBOUNCE(DB), .INVERT(8'h00)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(din_a),
        .data_filtered(filt_a), .rise_flags(rise_a), .fall_flags(fall_a),
        .flag_clear(clr_a), .changed(chg_a), .irq(irq_a)
    );

    expansion_input_filter #(
        .WIDTH(W), .SAMPLE_DIV(DIV), .DEBOUNCE(DB), .INVERT(INV_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(din_b),
        .data_filtered(filt_b), .rise_flags(rise_b), .fall_flags(fall_b),
        .flag_clear(clr_b), .changed(chg_b), .irq(irq_b)
    );

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Next model state: a bit flips after DB consecutive differing samples.
    function automatic mdl_t m_next(input mdl_t m, input logic [7:0] s,
                                    input logic [7:0] clr, input bit tk);
        mdl_t       n  = m;
        logic [7:0] sr = '0;
        logic [7:0] sf = '0;
        n.irq = |(m.rise | m.fall);
        n.chg = 1'b0;
        if (tk) begin
            for (int i = 0; i < W; i++) begin
                if (s[i] == m.filt[i]) begin
                    n.run[i] = '0;
                end else begin
                    n.run[i] = m.run[i] + 8'd1;
                    if (n.run[i] == 8'(DB)) begin
                        n.filt[i] = s[i];
                        n.run[i]  = '0;
                        n.chg     = 1'b1;
                        if (s[i]) sr[i] = 1'b1;
                        else      sf[i] = 1'b1;
                    end
                end
            end
        end
        n.rise = (m.rise & ~clr) | sr;
        n.fall = (m.fall & ~clr) | sf;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma    <= '0;
            mb    <= '0;
            m_cyc <= 0;
        end else begin
            ma    <= m_next(ma, din_a, clr_a, ((m_cyc + 1) % DIV) == 0);
            mb    <= m_next(mb, din_b ^ INV_B, clr_b, ((m_cyc + 1) % DIV) == 0);
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("a_filtered", filt_a, ma.filt);
        chk("a_rise", rise_a, ma.rise);
        chk("a_fall", fall_a, ma.fall);
        chk("a_changed", 8'(chg_a), 8'(ma.chg));
        chk("a_irq", 8'(irq_a), 8'(ma.irq));
        chk("b_filtered", filt_b, mb.filt);
        chk("b_rise", rise_b, mb.rise);
        chk("b_fall", fall_b, mb.fall);
        chk("b_changed", 8'(chg_b), 8'(mb.chg));
        chk("b_irq", 8'(irq_b), 8'(mb.irq));
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  t;
        bit  seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Quiet inputs; instance b sees bit 7 high through inversion.
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 11) chk("b_before_accept", filt_b, 8'h00);
            if (i == 12) begin
                chk("b_invert_accept", filt_b, 8'h80);
                chk("b_invert_rise", rise_b, 8'h80);
            end
        end
        chk("a_idle_filtered", filt_a, 8'h00);
        chk("a_idle_irq", 8'(irq_a), 8'h00);

        // Stable 0x05 accepted on the third tick.
        din_a = 8'h05;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (filt_a == 8'h05) break;
        end
        chk("accept_latency", 8'(n), 8'd12);
        chk("accept_rise", rise_a, 8'h05);
        chk("accept_changed", 8'(chg_a), 8'h01);
        chk("accept_irq_lag", 8'(irq_a), 8'h00);
        @(negedge clk);
        chk("irq_after_lag", 8'(irq_a), 8'h01);
        chk("changed_single", 8'(chg_a), 8'h00);

        // Bit 1 high for two ticks only.
        din_a = 8'h07;
        repeat (8) @(negedge clk);
        din_a = 8'h05;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seen |= chg_a;
        end
        chk("glitch_filtered", filt_a, 8'h05);
        chk("glitch_rise", rise_a, 8'h05);
        chk("glitch_changed", 8'(seen), 8'h00);

        // Write-1-to-clear.
        clr_a = 8'h01;
        @(negedge clk);
        clr_a = 8'h00;
        chk("clear_bit0", rise_a, 8'h04);
        clr_a = 8'h05;
        @(negedge clk);
        clr_a = 8'h00;
        chk("clear_all", rise_a, 8'h00);
        chk("irq_still_high", 8'(irq_a), 8'h01);
        @(negedge clk);
        chk("irq_dropped", 8'(irq_a), 8'h00);

        // Clear of bit 2 on the very tick its fall is accepted.
        din_a = 8'h01;
        t = 0;
        for (int i = 0; i < 40 && t < 3; i++) begin
            if (((m_cyc + 1) % DIV) == 0) t++;
            if (t == 3) clr_a = 8'h04;
            @(negedge clk);
        end
        clr_a = 8'h00;
        chk("set_wins_fall", fall_a, 8'h04);
        chk("set_wins_filtered", filt_a, 8'h01);
        chk("set_wins_changed", 8'(chg_a), 8'h01);

        clr_b = 8'h80;
        @(negedge clk);
        clr_b = 8'h00;
        chk("b_clear", rise_b, 8'h00);

        // Asynchronous reset mid-count with a flag set.
        din_a = 8'h05;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_filtered", filt_a, 8'h00);
        chk("rst_fall", fall_a, 8'h00);
        chk("rst_irq", 8'(irq_a), 8'h00);
        chk("rst_b_filtered", filt_b, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (filt_a == 8'h05) break;
        end
        chk("recount_latency", 8'(n), 8'd12);
        chk("recount_b", filt_b, 8'h80);
        chk("recount_rise", rise_a, 8'h05);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
